sram16_responder: RTL and testbench

Memory-side responder for the 16-bit data memory port driven by the CPU load/store memory interface. It decodes the interface's enable, read, write, address and data lines, and stores 2^ADDR_WIDTH halfwords. It returns read data after a fixed, parameterised latency. It flags illegal request combinations and can optionally count accesses for bench and debug use.

---
 rtl/sram16_responder.sv | 104 ++++++++++
 tb/tb_sram16_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram16_responder.sv
// sram16_responder: halfword SRAM responder for the CPU data port, fixed read latency.
// Ports: clk, reset, mem_enable/read_enable/write_enable, address, data_in -> data_out,
//   rd_valid, protocol_error, read_count, write_count. Counters need SRAM16_ACCESS_COUNT_EN.
module sram16_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_enable,
  input  logic                  read_enable,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  protocol_error,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  req_ok;
  logic                  rd_req;
  logic                  wr_req;
  logic                  collide;
  logic                  tail_v;
  logic [DATA_WIDTH-1:0] tail_d;

  assign req_ok  = !reset && mem_enable;
  assign rd_req  = req_ok && read_enable && !write_enable;
  assign wr_req  = req_ok && write_enable;
  assign collide = req_ok && read_enable && write_enable;
  assign rd_data = mem[address];

  // Array is never reset; writes in a collision still commit.
  always_ff @(posedge clk) begin
    if (wr_req) mem[address] <= data_in;
  end

  // The output register is the last latency stage, so only
  // READ_LATENCY-1 intermediate stages are needed.
  generate
    if (READ_LATENCY <= 1) begin : g_direct
      assign tail_v = rd_req;
      assign tail_d = rd_data;
    end else begin : g_pipe
      localparam int S = READ_LATENCY - 1;
      logic [S-1:0]          pv;
      logic [DATA_WIDTH-1:0] pd [S];

      always_ff @(posedge clk) begin
        if (reset) begin
          pv <= '0;
        end else begin
          pv[0] <= rd_req;
          for (int i = 1; i < S; i++) pv[i] <= pv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        pd[0] <= rd_data;
        for (int i = 1; i < S; i++) pd[i] <= pd[i-1];
      end

      assign tail_v = pv[S-1];
      assign tail_d = pd[S-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out       <= '0;
      rd_valid       <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      rd_valid       <= tail_v;
      protocol_error <= collide;
      if (tail_v) data_out <= tail_d;
    end
  end

`ifdef SRAM16_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count  <= '0;
      write_count <= '0;
    end else begin
      if (tail_v && read_count != 16'hFFFF)
        read_count <= read_count + 16'd1;
      if (wr_req && write_count != 16'hFFFF)
        write_count <= write_count + 16'd1;
    end
  end
`else
  assign read_count  = 16'h0000;
  assign write_count = 16'h0000;
`endif

endmodule

// File: tb/tb_sram16_responder.sv
// tb_sram16_responder: drives three responders (latency 1,2,3) with shared stimulus,
// checks table vectors, hand sequences and random traffic against a queue-based model.
module tb_sram16_responder;

  logic        clk = 1'b0;
  logic        reset, me, re, we;
  logic [11:0] addr;
  logic [15:0] din;

  logic [15:0] dout [3];
  logic        vld  [3];
  logic        perr [3];
  logic [15:0] rcnt [3];
  logic [15:0] wcnt [3];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  sram16_responder #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .mem_enable(me), .read_enable(re),
    .write_enable(we), .address(addr), .data_in(din),
    .data_out(dout[0]), .rd_valid(vld[0]), .protocol_error(perr[0]),
    .read_count(rcnt[0]), .write_count(wcnt[0]));

  sram16_responder #(.READ_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .mem_enable(me), .read_enable(re),
    .write_enable(we), .address(addr), .data_in(din),
    .data_out(dout[1]), .rd_valid(vld[1]), .protocol_error(perr[1]),
    .read_count(rcnt[1]), .write_count(wcnt[1]));

  sram16_responder #(.READ_LATENCY(3)) u3 (
    .clk(clk), .reset(reset), .mem_enable(me), .read_enable(re),
    .write_enable(we), .address(addr), .data_in(din),
    .data_out(dout[2]), .rd_valid(vld[2]), .protocol_error(perr[2]),
    .read_count(rcnt[2]), .write_count(wcnt[2]));

  // Reference model: memory as a sparse map, reads as due-dated queue entries.
  typedef struct {
    int          due;
    logic [15:0] d;
    bit          k;
  } ent_t;

  logic [15:0] mm [int];
  ent_t        pq [3][$];
  logic [15:0] em_d  [3];
  bit          em_k  [3];
  bit          em_v  [3];
  int          em_rc [3];
  bit          em_pe;
  int          em_wc;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[L%0d] cyc=%0d got=%h want=%h", nm, k + 1, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    ent_t e;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        pq[k].delete();
        em_d[k]  = 16'h0;
        em_k[k]  = 1'b1;
        em_v[k]  = 1'b0;
        em_rc[k] = 0;
      end
      em_pe = 1'b0;
      em_wc = 0;
      return;
    end
    em_pe = me && re && we;
    if (me && re && !we) begin
      for (int k = 0; k < 3; k++) begin
        e.due = cyc + k;
        e.k   = mm.exists(int'(addr));
        e.d   = e.k ? mm[int'(addr)] : 16'h0;
        pq[k].push_back(e);
      end
    end
    if (me && we) begin
      mm[int'(addr)] = din;
      if (em_wc < 65535) em_wc++;
    end
    for (int k = 0; k < 3; k++) begin
      em_v[k] = 1'b0;
      if (pq[k].size() > 0 && pq[k][0].due == cyc) begin
        e = pq[k].pop_front();
        em_v[k] = 1'b1;
        em_d[k] = e.d;
        em_k[k] = e.k;
        if (em_rc[k] < 65535) em_rc[k]++;
      end
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 3; k++) begin
      chk("rd_valid", k, 32'(vld[k]), 32'(em_v[k]));
      chk("protocol_error", k, 32'(perr[k]), 32'(em_pe));
      if (em_k[k]) chk("data_out", k, 32'(dout[k]), 32'(em_d[k]));
`ifdef SRAM16_ACCESS_COUNT_EN
      chk("read_count", k, 32'(rcnt[k]), 32'(em_rc[k]));
      chk("write_count", k, 32'(wcnt[k]), 32'(em_wc));
`else
      chk("read_count", k, 32'(rcnt[k]), 32'h0);
      chk("write_count", k, 32'(wcnt[k]), 32'h0);
`endif
    end
  endtask

  task automatic tick(input bit r, input bit m, input bit rd, input bit wr,
                      input logic [11:0] a, input logic [15:0] d);
    reset = r; me = m; re = rd; we = wr; addr = a; din = d;
    @(posedge clk);
    model_step();
    #1;
    check_model();
    cyc++;
  endtask

  typedef struct {
    bit          r, m, rd, wr;
    logic [11:0] a;
    logic [15:0] d;
    bit          ev;
    logic [15:0] ed;
    bit          epe;
  } vec_t;

  vec_t tbl [10];

  initial begin
    reset = 1'b1; me = 1'b0; re = 1'b0; we = 1'b0;
    addr = '0; din = '0;

    tbl[0] = '{1, 0, 0, 0, 12'h000, 16'h0000, 0, 16'h0000, 0};
    tbl[1] = '{0, 1, 0, 1, 12'h005, 16'hBEEF, 0, 16'h0000, 0};
    tbl[2] = '{0, 1, 1, 0, 12'h005, 16'h0000, 1, 16'hBEEF, 0};
    tbl[3] = '{0, 0, 0, 0, 12'h000, 16'h0000, 0, 16'hBEEF, 0};
    tbl[4] = '{0, 1, 1, 1, 12'h010, 16'hA5A5, 0, 16'hBEEF, 1};
    tbl[5] = '{0, 1, 1, 0, 12'h010, 16'h0000, 1, 16'hA5A5, 0};
    tbl[6] = '{0, 0, 1, 1, 12'h010, 16'h0F0F, 0, 16'hA5A5, 0};
    tbl[7] = '{0, 1, 1, 0, 12'h010, 16'h0000, 1, 16'hA5A5, 0};
    tbl[8] = '{0, 1, 0, 0, 12'h010, 16'h0000, 0, 16'hA5A5, 0};
    tbl[9] = '{0, 0, 0, 0, 12'h000, 16'h0000, 0, 16'hA5A5, 0};

    tick(1, 0, 0, 0, 12'h0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].r, tbl[i].m, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      chk("tbl_valid", 0, 32'(vld[0]), 32'(tbl[i].ev));
      chk("tbl_data", 0, 32'(dout[0]), 32'(tbl[i].ed));
      chk("tbl_perr", 0, 32'(perr[0]), 32'(tbl[i].epe));
    end

    // Back-to-back reads, latency 3 lags latency 1 by two cycles.
    tick(0, 1, 0, 1, 12'h000, 16'h1111);
    tick(0, 1, 0, 1, 12'h001, 16'h2222);
    tick(0, 1, 0, 1, 12'h002, 16'h3333);
    tick(0, 1, 1, 0, 12'h000, 16'h0);
    chk("b2b_l1_v", 0, 32'(vld[0]), 32'h1);
    chk("b2b_l1_d", 0, 32'(dout[0]), 32'h1111);
    chk("b2b_l3_v0", 2, 32'(vld[2]), 32'h0);
    tick(0, 1, 1, 0, 12'h001, 16'h0);
    chk("b2b_l3_v1", 2, 32'(vld[2]), 32'h0);
    tick(0, 1, 1, 0, 12'h002, 16'h0);
    chk("b2b_l1_d3", 0, 32'(dout[0]), 32'h3333);
    chk("b2b_l3_a", 2, 32'({vld[2], dout[2]}), 32'h1_1111);
    tick(0, 0, 0, 0, 12'h0, 16'h0);
    chk("b2b_l3_b", 2, 32'({vld[2], dout[2]}), 32'h1_2222);
    tick(0, 0, 0, 0, 12'h0, 16'h0);
    chk("b2b_l3_c", 2, 32'({vld[2], dout[2]}), 32'h1_3333);
    tick(0, 0, 0, 0, 12'h0, 16'h0);
    chk("b2b_l3_hold", 2, 32'({vld[2], dout[2]}), 32'h0_3333);

    // Reset lands while a latency-2 read is in flight.
    tick(0, 1, 1, 0, 12'h005, 16'h0);
    chk("rst_l2_pre", 1, 32'(vld[1]), 32'h0);
    tick(1, 1, 0, 1, 12'h005, 16'hDEAD);
    chk("rst_l2_a", 1, 32'({vld[1], dout[1]}), 32'h0_0000);
    tick(0, 0, 0, 0, 12'h0, 16'h0);
    chk("rst_l2_b", 1, 32'({vld[1], dout[1]}), 32'h0_0000);
    tick(0, 1, 1, 0, 12'h005, 16'h0);
    tick(0, 0, 0, 0, 12'h0, 16'h0);
    chk("rst_l2_rd", 1, 32'({vld[1], dout[1]}), 32'h1_BEEF);

    // Access counters: 5 writes, 3 reads, 1 collision.
    tick(1, 0, 0, 0, 12'h0, 16'h0);
    for (int i = 0; i < 5; i++)
      tick(0, 1, 0, 1, 12'(32 + i), 16'(16'h4000 + i));
    for (int i = 0; i < 3; i++)
      tick(0, 1, 1, 0, 12'(32 + i), 16'h0);
    tick(0, 1, 1, 1, 12'h025, 16'h7777);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 12'h0, 16'h0);
    for (int k = 0; k < 3; k++) begin
`ifdef SRAM16_ACCESS_COUNT_EN
      chk("cnt_wr", k, 32'(wcnt[k]), 32'd6);
      chk("cnt_rd", k, 32'(rcnt[k]), 32'd3);
`else
      chk("cnt_wr", k, 32'(wcnt[k]), 32'd0);
      chk("cnt_rd", k, 32'(rcnt[k]), 32'd0);
`endif
    end

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      automatic int sel = int'($urandom_range(0, 99));
      automatic bit r  = (sel < 2);
      automatic bit m  = ($urandom_range(0, 99) < 85);
      automatic int op = int'($urandom_range(0, 9));
      automatic bit rd = (op < 5) || (op == 9);
      automatic bit wr = (op >= 5);
      tick(r, m, rd, wr, 12'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
